// File: rtl/drive_pkg.sv
// Shared types and defaults for the rover drive command path.
//   drive_state_t : steering states, also exported on state_o for debug LEDs
//   frame_class_t : per-frame classification of the camera flags
//   classify()    : maps the turn_left/turn_right/centered flags to a class
package drive_pkg;

  typedef enum logic [2:0] {
    STOP    = 3'd0,
    FORWARD = 3'd1,
    TURN_L  = 3'd2,
    TURN_R  = 3'd3,
    SEARCH  = 3'd4
  } drive_state_t;

  typedef enum logic [1:0] {
    CLS_N = 2'd0,
    CLS_C = 2'd1,
    CLS_L = 2'd2,
    CLS_R = 2'd3
  } frame_class_t;

  localparam int unsigned PWM_PERIOD_DEF    = 1000;
  localparam int unsigned DUTY_FWD_DEF      = 700;
  localparam int unsigned DUTY_TURN_DEF     = 300;
  localparam int unsigned STABLE_FRAMES_DEF = 3;
  localparam int unsigned LOST_FRAMES_DEF   = 15;
  localparam int unsigned RAMP_STEP_DEF     = 20;
  localparam int unsigned CNT_W_DEF         = $clog2(PWM_PERIOD_DEF + 1);

  // Centered wins; a single turn flag picks a side; none or both means no target.
  function automatic frame_class_t classify(input logic left, input logic right,
                                            input logic centre);
    if (centre)             return CLS_C;
    else if (left ^ right)  return left ? CLS_L : CLS_R;
    else                    return CLS_N;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One wheel's PWM output stage.
//   clk_i, rst_i : clock, synchronous active-high reset
//   cnt_i        : shared PWM counter from the top
//   wrap_i       : high on the last count of a period
//   stop_i       : forces the pin low on the next edge and clears the applied duty
//   duty_i/dir_i : target duty (high cycles per period) and direction
//   pwm_o/dir_o  : registered motor pins
// Applied duty/dir only change at a wrap so a period is never cut short.
// With DRIVE_SOFTSTART_EN defined the applied duty ramps by RAMP_STEP per
// period, and a direction reversal ramps down to zero before flipping.
module pwm_channel
  import drive_pkg::*;
#(
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned RAMP_STEP = RAMP_STEP_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             wrap_i,
  input  logic             stop_i,
  input  logic [CNT_W-1:0] duty_i,
  input  logic             dir_i,
  output logic             pwm_o,
  output logic             dir_o
);

`ifdef DRIVE_SOFTSTART_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  // Without soft start the step covers the full range, so the target lands in one wrap.
  localparam int unsigned MAXV   = (2 ** CNT_W) - 1;
  localparam int unsigned STEP_R = SOFT ? RAMP_STEP : MAXV;
  localparam int unsigned STEP_C = (STEP_R > MAXV) ? MAXV : STEP_R;
  localparam logic [CNT_W-1:0] STEP = CNT_W'(STEP_C);

  logic [CNT_W-1:0] duty_q, duty_d;
  logic             dir_q, dir_d;
  logic             pwm_q;

  // Value to apply at the next wrap.
  always_comb begin
    duty_d = duty_q;
    dir_d  = dir_q;
    if (SOFT && (dir_i != dir_q)) begin
      if (duty_q == '0) dir_d  = dir_i;
      else              duty_d = (duty_q > STEP) ? duty_q - STEP : '0;
    end else begin
      dir_d = dir_i;
      if (duty_q < duty_i)
        duty_d = ((duty_i - duty_q) > STEP) ? duty_q + STEP : duty_i;
      else if (duty_q > duty_i)
        duty_d = ((duty_q - duty_i) > STEP) ? duty_q - STEP : duty_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      duty_q <= '0;
      dir_q  <= 1'b1;
      pwm_q  <= 1'b0;
    end else begin
      if (wrap_i) begin
        duty_q <= duty_d;
        dir_q  <= dir_d;
      end
      // STOP cuts the pulse immediately and restarts any ramp from zero.
      if (stop_i) begin
        duty_q <= '0;
        pwm_q  <= 1'b0;
      end else begin
        pwm_q  <= (cnt_i < duty_q);
      end
    end
  end

  assign pwm_o = pwm_q;
  assign dir_o = dir_q;

endmodule

// File: rtl/drive_command_fsm.sv
// Steering controller fed by camera_drive_flags.
//   clk_i, rst_i            : video clock, synchronous active-high reset
//   enable_i                : low forces STOP and clears the debounce state
//   frame_end_i             : one-cycle pulse; flags are valid on this cycle
//   turn_left_i/turn_right_i/centered_i : frame-held flags
//   pwm_*_o, dir_*_o        : wheel PWM and direction (1 = forward)
//   state_o                 : current drive_state_t for debug display
// Optional soft start inside pwm_channel: define DRIVE_SOFTSTART_EN.
module drive_command_fsm
  import drive_pkg::*;
#(
  parameter int unsigned PWM_PERIOD    = PWM_PERIOD_DEF,
  parameter int unsigned DUTY_FWD      = DUTY_FWD_DEF,
  parameter int unsigned DUTY_TURN     = DUTY_TURN_DEF,
  parameter int unsigned STABLE_FRAMES = STABLE_FRAMES_DEF,
  parameter int unsigned LOST_FRAMES   = LOST_FRAMES_DEF,
  parameter int unsigned RAMP_STEP     = RAMP_STEP_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       frame_end_i,
  input  logic       turn_left_i,
  input  logic       turn_right_i,
  input  logic       centered_i,
  output logic       pwm_left_o,
  output logic       pwm_right_o,
  output logic       dir_left_o,
  output logic       dir_right_o,
  output logic [2:0] state_o
);

  localparam int unsigned CNT_W  = $clog2(PWM_PERIOD + 1);
  localparam int unsigned STB_W  = $clog2(STABLE_FRAMES + 1);
  localparam int unsigned LOST_W = $clog2(LOST_FRAMES + 1);
  // Duties beyond a full period behave as constant-high, so clamp to fit the counter width.
  localparam int unsigned FWD_C  = (DUTY_FWD  > PWM_PERIOD) ? PWM_PERIOD : DUTY_FWD;
  localparam int unsigned TURN_C = (DUTY_TURN > PWM_PERIOD) ? PWM_PERIOD : DUTY_TURN;
  localparam logic [CNT_W-1:0] D_FWD  = CNT_W'(FWD_C);
  localparam logic [CNT_W-1:0] D_TURN = CNT_W'(TURN_C);

  drive_state_t      state_q;
  frame_class_t      cand_q, cls_c;
  logic [STB_W-1:0]  stable_q, stable_d;
  logic [LOST_W-1:0] lost_q, lost_d;
  logic [CNT_W-1:0]  pwm_cnt_q;
  logic              wrap_c;
  logic [CNT_W-1:0]  duty_l_c, duty_r_c;
  logic              dir_l_c, dir_r_c;

  // Debounce counter next values for the current frame's class.
  always_comb begin
    cls_c    = classify(turn_left_i, turn_right_i, centered_i);
    stable_d = STB_W'(1);
    if (cls_c == cand_q)
      stable_d = (stable_q == STB_W'(STABLE_FRAMES)) ? stable_q : stable_q + STB_W'(1);
    lost_d = '0;
    if (cls_c == CLS_N)
      lost_d = (lost_q == LOST_W'(LOST_FRAMES)) ? lost_q : lost_q + LOST_W'(1);
  end

  // Steering FSM and debounce registers; enable low overrides a coincident frame_end.
  always_ff @(posedge clk_i) begin
    if (rst_i || !enable_i) begin
      state_q  <= STOP;
      cand_q   <= CLS_N;
      stable_q <= '0;
      lost_q   <= '0;
    end else if (frame_end_i) begin
      cand_q   <= cls_c;
      stable_q <= stable_d;
      lost_q   <= lost_d;
      if ((cls_c != CLS_N) && (stable_d == STB_W'(STABLE_FRAMES))) begin
        case (cls_c)
          CLS_C:   state_q <= FORWARD;
          CLS_L:   state_q <= TURN_L;
          CLS_R:   state_q <= TURN_R;
          default: state_q <= state_q;
        endcase
      end else if ((cls_c == CLS_N) && (lost_d == LOST_W'(LOST_FRAMES))) begin
        state_q <= SEARCH;
      end
    end
  end

  // Free-running PWM period counter shared by both wheels.
  assign wrap_c = (pwm_cnt_q == CNT_W'(PWM_PERIOD - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i)       pwm_cnt_q <= '0;
    else if (wrap_c) pwm_cnt_q <= '0;
    else             pwm_cnt_q <= pwm_cnt_q + CNT_W'(1);
  end

  // Per-state wheel targets; SEARCH spins left in place.
  always_comb begin
    duty_l_c = '0;
    duty_r_c = '0;
    dir_l_c  = 1'b1;
    dir_r_c  = 1'b1;
    case (state_q)
      FORWARD: begin duty_l_c = D_FWD;  duty_r_c = D_FWD;  end
      TURN_L:  begin duty_l_c = D_TURN; duty_r_c = D_FWD;  end
      TURN_R:  begin duty_l_c = D_FWD;  duty_r_c = D_TURN; end
      SEARCH:  begin duty_l_c = D_TURN; duty_r_c = D_TURN; dir_l_c = 1'b0; end
      default: ;
    endcase
  end

  pwm_channel #(.CNT_W(CNT_W), .RAMP_STEP(RAMP_STEP)) u_left (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .cnt_i  (pwm_cnt_q),
    .wrap_i (wrap_c),
    .stop_i (state_q == STOP),
    .duty_i (duty_l_c),
    .dir_i  (dir_l_c),
    .pwm_o  (pwm_left_o),
    .dir_o  (dir_left_o)
  );

  pwm_channel #(.CNT_W(CNT_W), .RAMP_STEP(RAMP_STEP)) u_right (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .cnt_i  (pwm_cnt_q),
    .wrap_i (wrap_c),
    .stop_i (state_q == STOP),
    .duty_i (duty_r_c),
    .dir_i  (dir_r_c),
    .pwm_o  (pwm_right_o),
    .dir_o  (dir_right_o)
  );

  assign state_o = state_q;

endmodule
